// File: rtl/uart_rx_cmd_ctrl.sv
// Turns the UART receiver's byte stream into register writes: finds SYNC, parses ADDR/LEN/payload/XOR-checksum
// frames, buffers the payload and replays a verified frame as a burst over a valid/ready write port.
//
// state   | meaning
// HUNT    | idle, waiting for SYNC_BYTE
// ADDR    | expecting base address byte
// LEN     | expecting payload length byte
// PAYLOAD | collecting payload bytes into the buffer
// CHECK   | expecting XOR checksum byte
// DRAIN   | issuing buffered writes, one per handshake
module uart_rx_cmd_ctrl #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 14000000
) (
    input  logic       clk,
    input  logic       r_reset,
    input  logic [7:0] i_byte,
    input  logic       i_byte_valid,
    output logic       o_wr_valid,
    output logic [7:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    input  logic       i_wr_ready,
    output logic       o_busy,
    output logic [7:0] o_frames_ok,
    output logic [7:0] o_err_chk,
    output logic [7:0] o_err_timeout,
    output logic [7:0] o_err_overrun
);

    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {HUNT, ADDR, LEN, PAYLOAD, CHECK, DRAIN} state_t;

    state_t          r_state, w_state_n;
    logic [7:0]      r_base, r_len, r_idx, r_chk;
    logic [TW-1:0]   r_idle;
    logic [7:0]      r_buf [2**IW];
    logic [7:0]      r_frames_ok, r_err_chk, r_err_timeout, r_err_overrun;
    logic            w_in_frame, w_expired, w_last;
    logic            w_inc_ok, w_inc_chk, w_inc_to, w_inc_ovr;
    logic            w_drain;

    assign w_in_frame = (r_state == ADDR) || (r_state == LEN) || (r_state == PAYLOAD) || (r_state == CHECK);
    assign w_expired  = (r_idle == TW'(TIMEOUT_CYCLES - 1));
    assign w_last     = (r_idx == r_len - 8'd1);
    assign w_drain    = (r_state == DRAIN);

    always_comb begin
        w_state_n = r_state;
        w_inc_ok  = 1'b0;
        w_inc_chk = 1'b0;
        w_inc_to  = 1'b0;
        w_inc_ovr = 1'b0;
        case (r_state)
            HUNT: begin
                if (i_byte_valid && i_byte == SYNC_BYTE) w_state_n = ADDR;
            end
            ADDR: begin
                if (i_byte_valid) w_state_n = LEN;
            end
            LEN: begin
                if (i_byte_valid) begin
                    if (i_byte == 8'd0 || int'(i_byte) > MAX_LEN) begin
                        w_inc_chk = 1'b1;
                        w_state_n = HUNT;
                    end else begin
                        w_state_n = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (i_byte_valid && w_last) w_state_n = CHECK;
            end
            CHECK: begin
                if (i_byte_valid) begin
                    if (i_byte == r_chk) begin
                        w_state_n = DRAIN;
                    end else begin
                        w_inc_chk = 1'b1;
                        w_state_n = HUNT;
                    end
                end
            end
            DRAIN: begin
                w_inc_ovr = i_byte_valid;
                if (i_wr_ready && w_last) begin
                    w_inc_ok  = 1'b1;
                    w_state_n = HUNT;
                end
            end
            default: w_state_n = HUNT;
        endcase
        // A byte landing on the expiry cycle takes priority over the timeout.
        if (w_in_frame && !i_byte_valid && w_expired) begin
            w_inc_to  = 1'b1;
            w_state_n = HUNT;
        end
    end

    always_ff @(posedge clk) begin
        if (r_reset) begin
            r_state       <= HUNT;
            r_base        <= 8'd0;
            r_len         <= 8'd0;
            r_idx         <= 8'd0;
            r_chk         <= 8'd0;
            r_idle        <= '0;
            r_frames_ok   <= 8'd0;
            r_err_chk     <= 8'd0;
            r_err_timeout <= 8'd0;
            r_err_overrun <= 8'd0;
        end else begin
            r_state <= w_state_n;
            if (w_in_frame && !i_byte_valid && !w_expired) r_idle <= r_idle + TW'(1);
            else                                           r_idle <= '0;
            case (r_state)
                ADDR: if (i_byte_valid) begin
                    r_base <= i_byte;
                    r_chk  <= i_byte;
                end
                LEN: if (i_byte_valid) begin
                    r_len <= i_byte;
                    r_chk <= r_chk ^ i_byte;
                    r_idx <= 8'd0;
                end
                PAYLOAD: if (i_byte_valid) begin
                    r_chk <= r_chk ^ i_byte;
                    r_idx <= r_idx + 8'd1;
                end
                CHECK: if (i_byte_valid) r_idx <= 8'd0;
                DRAIN: if (i_wr_ready) r_idx <= r_idx + 8'd1;
                default: ;
            endcase
            if (w_inc_ok  && r_frames_ok   != 8'hFF) r_frames_ok   <= r_frames_ok + 8'd1;
            if (w_inc_chk && r_err_chk     != 8'hFF) r_err_chk     <= r_err_chk + 8'd1;
            if (w_inc_to  && r_err_timeout != 8'hFF) r_err_timeout <= r_err_timeout + 8'd1;
            if (w_inc_ovr && r_err_overrun != 8'hFF) r_err_overrun <= r_err_overrun + 8'd1;
        end
    end

    // Payload storage needs no reset; its contents are only visible while draining.
    always_ff @(posedge clk) begin
        if (r_state == PAYLOAD && i_byte_valid) r_buf[r_idx[IW-1:0]] <= i_byte;
    end

    assign o_wr_valid    = w_drain;
    assign o_wr_addr     = w_drain ? r_base + r_idx : 8'd0;
    assign o_wr_data     = w_drain ? r_buf[r_idx[IW-1:0]] : 8'd0;
    assign o_busy        = (r_state != HUNT);
    assign o_frames_ok   = r_frames_ok;
    assign o_err_chk     = r_err_chk;
    assign o_err_timeout = r_err_timeout;
    assign o_err_overrun = r_err_overrun;

endmodule
